pc_call_stack: RTL and testbench

- Parametrised successor to the 5-bit program counter.
- Keeps the load-from-IR and increment operations, and adds:
  - skip-next (PC+2, for conditional-skip instructions);
  - subroutine call/return through an internal LIFO of return addresses;
  - sticky stack-error flags.
- Sits between the controller strobes and the address mux, driving pc_addr to memory.

---
 rtl/pc_pkg.sv | 39 +++
 rtl/lifo_stack.sv | 56 +++++
 rtl/pc_call_stack.sv | 105 ++++++++++
 tb/tb_pc_call_stack.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared constants and operation-select encoding for the program counter
// with return-address stack.
package pc_pkg;

  localparam int PC_ADDR_WIDTH   = 5;
  localparam int PC_STACK_DEPTH  = 4;
  localparam int PC_RESET_VECTOR = 0;

  typedef enum logic [2:0] {
    OP_HOLD = 3'd0,
    OP_INC  = 3'd1,
    OP_SKIP = 3'd2,
    OP_LD   = 3'd3,
    OP_CALL = 3'd4,
    OP_RET  = 3'd5
  } pc_op_e;

  // Highest-priority strobe wins: ret > call > ld > skip > inc.
  function automatic pc_op_e sel_op(input logic ret, input logic call,
                                    input logic ld, input logic skip,
                                    input logic inc);
    pc_op_e op;
    if (ret) begin
      op = OP_RET;
    end else if (call) begin
      op = OP_CALL;
    end else if (ld) begin
      op = OP_LD;
    end else if (skip) begin
      op = OP_SKIP;
    end else if (inc) begin
      op = OP_INC;
    end else begin
      op = OP_HOLD;
    end
    return op;
  endfunction

endpackage

// File: rtl/lifo_stack.sv
// Return-address LIFO: register array plus depth counter. Push is ignored
// when full and pop is ignored when empty; the caller flags those cases.
module lifo_stack #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           push_data,
  output logic [WIDTH-1:0]           top_data,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       full,
  output logic                       empty
);

  localparam int DEPTH_W = $clog2(DEPTH + 1);
  localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0]   entries_r [DEPTH];
  logic [DEPTH_W-1:0] depth_r;
  logic [DEPTH_W-1:0] depth_m1_s;
  logic [IDX_W-1:0]   wr_idx_s;
  logic [IDX_W-1:0]   rd_idx_s;
  logic               do_push_s;
  logic               do_pop_s;

  assign depth_m1_s = depth_r - DEPTH_W'(1);
  assign wr_idx_s   = depth_r[IDX_W-1:0];
  assign rd_idx_s   = depth_m1_s[IDX_W-1:0];
  assign full       = (depth_r == DEPTH_W'(DEPTH));
  assign empty      = (depth_r == DEPTH_W'(0));
  assign do_push_s  = push & ~full;
  assign do_pop_s   = pop & ~empty & ~push;
  assign top_data   = entries_r[rd_idx_s];
  assign depth      = depth_r;

  // Depth counter and entry storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      depth_r <= DEPTH_W'(0);
      for (int k = 0; k < DEPTH; k++) begin
        entries_r[k] <= {WIDTH{1'b0}};
      end
    end else if (do_push_s) begin
      entries_r[wr_idx_s] <= push_data;
      depth_r             <= depth_r + DEPTH_W'(1);
    end else if (do_pop_s) begin
      depth_r <= depth_m1_s;
    end else begin
      depth_r <= depth_r;
    end
  end

endmodule

// File: rtl/pc_call_stack.sv
// Program counter with jump, increment, skip and call/return through an
// internal return-address stack, plus sticky overflow/underflow flags.
module pc_call_stack
  import pc_pkg::*;
#(
  parameter int ADDR_WIDTH   = PC_ADDR_WIDTH,
  parameter int STACK_DEPTH  = PC_STACK_DEPTH,
  parameter int RESET_VECTOR = PC_RESET_VECTOR
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             ld_pc,
  input  logic                             inc_pc,
  input  logic                             skip_pc,
  input  logic                             call_pc,
  input  logic                             ret_pc,
  input  logic                             clr_err,
  input  logic [ADDR_WIDTH-1:0]            ir_addr,
  output logic [ADDR_WIDTH-1:0]            pc_addr,
  output logic [$clog2(STACK_DEPTH+1)-1:0] stk_depth,
  output logic                             stk_empty,
  output logic                             stk_full,
  output logic                             stk_ovf,
  output logic                             stk_unf
);

  pc_op_e                op_s;
  logic [ADDR_WIDTH-1:0] pc_r;
  logic [ADDR_WIDTH-1:0] pc_next_s;
  logic [ADDR_WIDTH-1:0] pc_plus1_s;
  logic [ADDR_WIDTH-1:0] top_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  ovf_set_s;
  logic                  unf_set_s;
  logic                  ovf_r;
  logic                  unf_r;

  assign op_s       = sel_op(ret_pc, call_pc, ld_pc, skip_pc, inc_pc);
  assign pc_plus1_s = pc_r + ADDR_WIDTH'(1);

  lifo_stack #(
    .WIDTH (ADDR_WIDTH),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .pop       (pop_s),
    .push_data (pc_plus1_s),
    .top_data  (top_s),
    .depth     (stk_depth),
    .full      (stk_full),
    .empty     (stk_empty)
  );

  // Next-PC mux and stack control; a blocked call/return raises its error.
  always_comb begin
    pc_next_s = pc_r;
    push_s    = 1'b0;
    pop_s     = 1'b0;
    ovf_set_s = 1'b0;
    unf_set_s = 1'b0;
    case (op_s)
      OP_RET: begin
        if (!stk_empty) begin
          pop_s     = 1'b1;
          pc_next_s = top_s;
        end else begin
          unf_set_s = 1'b1;
        end
      end
      OP_CALL: begin
        if (!stk_full) begin
          push_s    = 1'b1;
          pc_next_s = ir_addr;
        end else begin
          ovf_set_s = 1'b1;
        end
      end
      OP_LD:   pc_next_s = ir_addr;
      OP_SKIP: pc_next_s = pc_r + ADDR_WIDTH'(2);
      OP_INC:  pc_next_s = pc_plus1_s;
      default: pc_next_s = pc_r;
    endcase
  end

  // PC register and sticky error flags; a new error outranks clr_err.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_r  <= ADDR_WIDTH'(RESET_VECTOR);
      ovf_r <= 1'b0;
      unf_r <= 1'b0;
    end else begin
      pc_r  <= pc_next_s;
      ovf_r <= ovf_set_s | (ovf_r & ~clr_err);
      unf_r <= unf_set_s | (unf_r & ~clr_err);
    end
  end

  assign pc_addr = pc_r;
  assign stk_ovf = ovf_r;
  assign stk_unf = unf_r;

endmodule

// File: tb/tb_pc_call_stack.sv
// Self-checking bench for pc_call_stack: directed scenarios followed by
// randomized strobes compared against a queue-based reference model.
module tb_pc_call_stack;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ld_pc = 1'b0, inc_pc = 1'b0, skip_pc = 1'b0;
  logic       call_pc = 1'b0, ret_pc = 1'b0, clr_err = 1'b0;
  logic [4:0] ir_addr = 5'd0;
  logic [4:0] pc_addr;
  logic [2:0] stk_depth;
  logic       stk_empty, stk_full, stk_ovf, stk_unf;

  int vectors = 0;
  int miscompares = 0;

  // Reference model
  int m_pc = 0;
  int m_stk[$];
  bit m_ovf = 1'b0;
  bit m_unf = 1'b0;

  pc_call_stack #(.ADDR_WIDTH(5), .STACK_DEPTH(4), .RESET_VECTOR(0)) dut (
    .clk(clk), .rst(rst), .ld_pc(ld_pc), .inc_pc(inc_pc), .skip_pc(skip_pc),
    .call_pc(call_pc), .ret_pc(ret_pc), .clr_err(clr_err), .ir_addr(ir_addr),
    .pc_addr(pc_addr), .stk_depth(stk_depth), .stk_empty(stk_empty),
    .stk_full(stk_full), .stk_ovf(stk_ovf), .stk_unf(stk_unf)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_pc = 0;
    m_stk.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  // Drive one cycle of strobes, advance the model, sample #1 after the edge.
  task automatic step(input bit r, input bit c, input bit l, input bit s,
                      input bit i, input bit e, input int a);
    @(negedge clk);
    ret_pc = r; call_pc = c; ld_pc = l; skip_pc = s; inc_pc = i; clr_err = e;
    ir_addr = 5'(a);
    @(posedge clk);
    if (e) begin
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end
    if (r) begin
      if (m_stk.size() > 0) m_pc = m_stk.pop_back();
      else m_unf = 1'b1;
    end else if (c) begin
      if (m_stk.size() < 4) begin
        m_stk.push_back((m_pc + 1) % 32);
        m_pc = a % 32;
      end else m_ovf = 1'b1;
    end else if (l) m_pc = a % 32;
    else if (s) m_pc = (m_pc + 2) % 32;
    else if (i) m_pc = (m_pc + 1) % 32;
    #1;
    ret_pc = 1'b0; call_pc = 1'b0; ld_pc = 1'b0; skip_pc = 1'b0;
    inc_pc = 1'b0; clr_err = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #3;
    vectors++;
    if (pc_addr !== 5'd0 || stk_depth !== 3'd0 || stk_empty !== 1'b1 ||
        stk_full !== 1'b0 || stk_ovf !== 1'b0 || stk_unf !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: pc=%0d depth=%0d e=%b f=%b o=%b u=%b, expected 0 0 1 0 0 0",
               pc_addr, stk_depth, stk_empty, stk_full, stk_ovf, stk_unf);
    end
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_inc_skip_wrap();
    int exp_seq[6] = '{1, 2, 30, 0, 31, 0};
    int got[6];
    step(0, 0, 0, 0, 1, 0, 0);  got[0] = pc_addr;
    step(0, 0, 0, 0, 1, 0, 0);  got[1] = pc_addr;
    step(0, 0, 1, 0, 0, 0, 30); got[2] = pc_addr;
    step(0, 0, 0, 1, 0, 0, 0);  got[3] = pc_addr;
    step(0, 0, 1, 0, 0, 0, 31); got[4] = pc_addr;
    step(0, 0, 0, 0, 1, 0, 0);  got[5] = pc_addr;
    for (int k = 0; k < 6; k++) begin
      vectors++;
      if (got[k] != exp_seq[k]) begin
        miscompares++;
        $display("FAIL inc_skip_wrap[%0d]: pc=%0d expected %0d", k, got[k], exp_seq[k]);
      end
    end
    step(0, 0, 1, 0, 0, 0, 31);
    step(0, 0, 0, 1, 0, 0, 0);
    vectors++;
    if (pc_addr !== 5'd1) begin
      miscompares++;
      $display("FAIL skip_from_31: pc=%0d expected 1", pc_addr);
    end
  endtask

  task automatic test_call_return();
    step(0, 0, 1, 0, 0, 0, 2);
    step(0, 1, 0, 0, 0, 0, 21);
    vectors++;
    if (pc_addr !== 5'd21 || stk_depth !== 3'd1 || stk_empty !== 1'b0) begin
      miscompares++;
      $display("FAIL call: pc=%0d depth=%0d expected 21 1", pc_addr, stk_depth);
    end
    step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    vectors++;
    if (pc_addr !== 5'd23) begin
      miscompares++;
      $display("FAIL call_inc: pc=%0d expected 23", pc_addr);
    end
    step(1, 0, 0, 0, 0, 0, 0);
    vectors++;
    if (pc_addr !== 5'd3 || stk_empty !== 1'b1 || stk_depth !== 3'd0) begin
      miscompares++;
      $display("FAIL return: pc=%0d empty=%b expected 3 1", pc_addr, stk_empty);
    end
  endtask

  task automatic test_nested_overflow();
    int tgt[4] = '{8, 16, 24, 4};
    int rets[4] = '{25, 17, 9, 4};
    foreach (tgt[k]) step(0, 1, 0, 0, 0, 0, tgt[k]);
    vectors++;
    if (stk_depth !== 3'd4 || stk_full !== 1'b1 || pc_addr !== 5'd4) begin
      miscompares++;
      $display("FAIL nested: depth=%0d full=%b pc=%0d expected 4 1 4", stk_depth, stk_full, pc_addr);
    end
    step(0, 1, 0, 0, 0, 0, 12);
    vectors++;
    if (pc_addr !== 5'd4 || stk_ovf !== 1'b1 || stk_depth !== 3'd4) begin
      miscompares++;
      $display("FAIL overflow: pc=%0d ovf=%b depth=%0d expected 4 1 4", pc_addr, stk_ovf, stk_depth);
    end
    foreach (rets[k]) begin
      step(1, 0, 0, 0, 0, 0, 0);
      vectors++;
      if (pc_addr !== 5'(rets[k]) || stk_ovf !== 1'b1) begin
        miscompares++;
        $display("FAIL unwind[%0d]: pc=%0d ovf=%b expected %0d 1", k, pc_addr, stk_ovf, rets[k]);
      end
    end
    step(0, 0, 0, 0, 0, 1, 0);
    vectors++;
    if (stk_ovf !== 1'b0 || stk_unf !== 1'b0 || pc_addr !== 5'd4) begin
      miscompares++;
      $display("FAIL clr_err: ovf=%b unf=%b pc=%0d expected 0 0 4", stk_ovf, stk_unf, pc_addr);
    end
  endtask

  task automatic test_underflow();
    step(0, 0, 1, 0, 0, 0, 7);
    step(1, 0, 0, 0, 0, 0, 0);
    vectors++;
    if (pc_addr !== 5'd7 || stk_unf !== 1'b1 || stk_depth !== 3'd0) begin
      miscompares++;
      $display("FAIL underflow: pc=%0d unf=%b depth=%0d expected 7 1 0", pc_addr, stk_unf, stk_depth);
    end
    step(0, 0, 0, 0, 0, 1, 0);
  endtask

  task automatic test_priority();
    step(0, 0, 1, 0, 1, 0, 9);
    vectors++;
    if (pc_addr !== 5'd9) begin
      miscompares++;
      $display("FAIL inc_vs_ld: pc=%0d expected 9", pc_addr);
    end
    step(0, 1, 0, 0, 0, 0, 20);
    step(1, 1, 0, 0, 0, 0, 3);
    vectors++;
    if (pc_addr !== 5'd10 || stk_depth !== 3'd0) begin
      miscompares++;
      $display("FAIL call_vs_ret: pc=%0d depth=%0d expected 10 0", pc_addr, stk_depth);
    end
    step(1, 0, 0, 0, 0, 1, 0);
    vectors++;
    if (stk_unf !== 1'b1) begin
      miscompares++;
      $display("FAIL clr_vs_unf: unf=%b expected 1", stk_unf);
    end
    step(0, 0, 0, 0, 0, 1, 0);
  endtask

  task automatic test_async_reset();
    step(0, 1, 0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 0, 2);
    step(0, 1, 0, 0, 0, 0, 3);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    vectors++;
    if (pc_addr !== 5'd0 || stk_depth !== 3'd0 || stk_empty !== 1'b1) begin
      miscompares++;
      $display("FAIL async_reset: pc=%0d depth=%0d expected 0 0", pc_addr, stk_depth);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    step(1, 0, 0, 0, 0, 0, 0);
    vectors++;
    if (stk_unf !== 1'b1 || pc_addr !== 5'd0 || stk_depth !== 3'd0) begin
      miscompares++;
      $display("FAIL ret_after_reset: unf=%b pc=%0d depth=%0d expected 1 0 0", stk_unf, pc_addr, stk_depth);
    end
  endtask

  task automatic test_random();
    bit r, c, l, s, i, e;
    for (int n = 0; n < 400; n++) begin
      r = ($urandom_range(0, 99) < 20);
      c = ($urandom_range(0, 99) < 25);
      l = ($urandom_range(0, 99) < 15);
      s = ($urandom_range(0, 99) < 15);
      i = ($urandom_range(0, 99) < 30);
      e = ($urandom_range(0, 99) < 10);
      step(r, c, l, s, i, e, int'($urandom_range(0, 31)));
      vectors++;
      if (pc_addr !== 5'(m_pc) || stk_depth !== 3'(m_stk.size()) ||
          stk_empty !== (m_stk.size() == 0) || stk_full !== (m_stk.size() == 4) ||
          stk_ovf !== m_ovf || stk_unf !== m_unf) begin
        miscompares++;
        $display("FAIL random[%0d]: pc=%0d d=%0d e=%b f=%b o=%b u=%b expected pc=%0d d=%0d o=%b u=%b",
                 n, pc_addr, stk_depth, stk_empty, stk_full, stk_ovf, stk_unf,
                 m_pc, m_stk.size(), m_ovf, m_unf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_inc_skip_wrap();
    test_call_return();
    test_nested_overflow();
    test_underflow();
    test_priority();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
